// File: rtl/clock_enable_sequencer_if.sv
// rtl/clock_enable_sequencer_if.sv - control/status bundle of the CPU clock-enable sequencer
//
// Ports carried (direction as seen by the sequencer, modport slave):
//   manual_btn  in   raw asynchronous step button
//   select      in   raw asynchronous mode select, 1 = manual, 0 = auto
//   halt        in   synchronous level from the CPU HLT decode
//   resume      in   synchronous pulse that clears the halted state
//   tick_en     out  one-cycle clock-enable pulse for the CPU
//   halted      out  high while halted
//   manual_mode out  high while in manual mode
//   tick_count  out  16-bit count of issued ticks, wrapping
interface clock_enable_sequencer_if;
    logic        manual_btn;
    logic        select;
    logic        halt;
    logic        resume;
    logic        tick_en;
    logic        halted;
    logic        manual_mode;
    logic [15:0] tick_count;

    modport slave (
        input  manual_btn,
        input  select,
        input  halt,
        input  resume,
        output tick_en,
        output halted,
        output manual_mode,
        output tick_count
    );

    modport master (
        output manual_btn,
        output select,
        output halt,
        output resume,
        input  tick_en,
        input  halted,
        input  manual_mode,
        input  tick_count
    );
endinterface

// File: rtl/clock_enable_sequencer.sv
// rtl/clock_enable_sequencer.sv - single-cycle CPU clock-enable generator (auto / manual step / halt)
//
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   bus  clock_enable_sequencer_if.slave
//        inputs  manual_btn, select, halt, resume
//        outputs tick_en, halted, manual_mode, tick_count[15:0]
module clock_enable_sequencer #(
    parameter int SOURCE_CLK      = 100_000_000,
    parameter int TARGET_CLK      = 5,
    parameter int DEBOUNCE_CYCLES = 10_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    clock_enable_sequencer_if.slave   bus
);

    localparam int DIVISOR = SOURCE_CLK / TARGET_CLK;
    localparam int RATE_W  = $clog2(DIVISOR);
    localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(DIVISOR - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_AUTO   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic                   r_db_level;
    logic [DEB_W-1:0]       r_deb_cnt;
    logic [RATE_W-1:0]      r_rate_cnt;
    logic                   r_press;
    logic                   r_tick;
    logic [15:0]            r_tick_count;
    logic                   r_halted;
    logic                   r_manual_mode;
    state_t                 r_state;
    state_t                 w_next_state;

    logic w_btn;
    logic w_sel;
    logic w_db_rise;
    logic w_stay_auto;
    logic w_stay_manual;
    logic w_tick_next;

    assign w_btn = r_btn_sync[SYNC_STAGES-1];
    assign w_sel = r_sel_sync[SYNC_STAGES-1];

    // The debounced level flips on the last of DEBOUNCE_CYCLES consecutive
    // differing cycles; only the 0->1 flip counts as a press.
    assign w_db_rise = (w_btn != r_db_level) && (r_deb_cnt == DEB_MAX) && w_btn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_sync <= '0;
            r_sel_sync <= '0;
        end else begin
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], bus.manual_btn};
            r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], bus.select};
        end
    end

    // The debouncer runs in every state so a button held through a halt is
    // already settled afterwards, but a rise seen outside MANUAL is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_level <= 1'b0;
            r_deb_cnt  <= '0;
        end else if (w_btn == r_db_level) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_MAX) begin
            r_db_level <= w_btn;
            r_deb_cnt  <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_AUTO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Halt dominates everything, including a resume in the same cycle and a
    // tick that would otherwise have been issued this cycle.
    always_comb begin
        w_next_state = r_state;
        if (bus.halt) begin
            w_next_state = ST_HALTED;
        end else begin
            case (r_state)
                ST_HALTED: if (bus.resume) w_next_state = w_sel ? ST_MANUAL : ST_AUTO;
                ST_AUTO:   if (w_sel)      w_next_state = ST_MANUAL;
                ST_MANUAL: if (!w_sel)     w_next_state = ST_AUTO;
                default:                   w_next_state = ST_AUTO;
            endcase
        end

        // Ticks and presses only survive cycles with no mode change.
        w_stay_auto   = (r_state == ST_AUTO)   && (w_next_state == ST_AUTO);
        w_stay_manual = (r_state == ST_MANUAL) && (w_next_state == ST_MANUAL);
        w_tick_next   = (w_stay_auto && (r_rate_cnt == RATE_MAX)) ||
                        (w_stay_manual && r_press);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rate_cnt    <= '0;
            r_press       <= 1'b0;
            r_tick        <= 1'b0;
            r_tick_count  <= 16'd0;
            r_halted      <= 1'b0;
            r_manual_mode <= 1'b0;
        end else begin
            if (w_stay_auto) begin
                r_rate_cnt <= (r_rate_cnt == RATE_MAX) ? '0 : r_rate_cnt + RATE_W'(1);
            end else begin
                r_rate_cnt <= '0;
            end
            r_press       <= w_db_rise && w_stay_manual;
            r_tick        <= w_tick_next;
            r_tick_count  <= r_tick_count + {15'd0, w_tick_next};
            r_halted      <= (w_next_state == ST_HALTED);
            r_manual_mode <= (w_next_state == ST_MANUAL);
        end
    end

    assign bus.tick_en     = r_tick;
    assign bus.halted      = r_halted;
    assign bus.manual_mode = r_manual_mode;
    assign bus.tick_count  = r_tick_count;

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// tb/tb_clock_enable_sequencer.sv - self-checking bench for clock_enable_sequencer
module tb_clock_enable_sequencer;

    localparam int SRC  = 20;
    localparam int TGT  = 2;
    localparam int DIV  = 10;
    localparam int DEB  = 4;
    localparam int SYNC = 2;

    localparam int M_AUTO = 0;
    localparam int M_MAN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_enable_sequencer_if bus();

    clock_enable_sequencer #(
        .SOURCE_CLK      (SRC),
        .TARGET_CLK      (TGT),
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: edge counter since reset, raw input history, and the
    // edge at which AUTO was last entered (auto ticks fall on multiples of DIV
    // after it).
    int          n;
    bit          raw_btn_q[$];
    bit          raw_sel_q[$];
    bit          sb_q[$];
    int          m_state;
    bit          m_db;
    int          m_auto_e;
    int          m_press_edge;
    logic [15:0] m_count;
    bit          m_tick;

    bit          prev_tick_dut;
    int          dut_ticks;
    int          tick_edges[$];

    typedef struct {
        bit sel;
        bit btn;
        bit halt;
        bit resume;
        int cycles;
        int ticks;
        bit halted;
        bit manual;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        raw_btn_q.delete();
        raw_sel_q.delete();
        sb_q.delete();
        m_state      = M_AUTO;
        m_db         = 1'b0;
        m_auto_e     = 0;
        m_press_edge = -10;
        m_count      = 16'd0;
        m_tick       = 1'b0;
    endtask

    task automatic model_edge(input bit btn, input bit sel, input bit halt, input bit resume);
        int nxt;
        bit sb, ss, flip, changed;
        n++;
        raw_btn_q.push_back(btn);
        raw_sel_q.push_back(sel);
        sb = (n > SYNC) ? raw_btn_q[n-1-SYNC] : 1'b0;
        ss = (n > SYNC) ? raw_sel_q[n-1-SYNC] : 1'b0;
        sb_q.push_back(sb);
        flip = 1'b0;
        if (sb_q.size() >= DEB) begin
            flip = 1'b1;
            for (int i = 0; i < DEB; i++)
                if (sb_q[sb_q.size()-1-i] == m_db) flip = 1'b0;
        end
        nxt = m_state;
        if (halt)                          nxt = M_HALT;
        else if (m_state == M_HALT)        begin if (resume) nxt = ss ? M_MAN : M_AUTO; end
        else if (m_state == M_AUTO && ss)  nxt = M_MAN;
        else if (m_state == M_MAN && !ss)  nxt = M_AUTO;
        changed = (nxt != m_state);
        m_tick = 1'b0;
        if (!changed && nxt == M_AUTO && ((n - m_auto_e) % DIV) == 0) m_tick = 1'b1;
        if (!changed && nxt == M_MAN && m_press_edge == n - 1)        m_tick = 1'b1;
        if (flip && !m_db && !changed && nxt == M_MAN) m_press_edge = n;
        if (flip) m_db = !m_db;
        if (changed && nxt == M_AUTO) m_auto_e = n;
        if (m_tick) m_count++;
        m_state = nxt;
    endtask

    task automatic step(input bit btn, input bit sel, input bit halt, input bit resume);
        bus.manual_btn = btn;
        bus.select     = sel;
        bus.halt       = halt;
        bus.resume     = resume;
        @(posedge clk);
        model_edge(btn, sel, halt, resume);
        @(negedge clk);
        check("tick_en",     {31'd0, bus.tick_en},     {31'd0, m_tick});
        check("halted",      {31'd0, bus.halted},      {31'd0, m_state == M_HALT});
        check("manual_mode", {31'd0, bus.manual_mode}, {31'd0, m_state == M_MAN});
        check("tick_count",  {16'd0, bus.tick_count},  {16'd0, m_count});
        if (bus.tick_en) begin
            check("tick_back_to_back", {31'd0, prev_tick_dut}, 32'd0);
            tick_edges.push_back(n);
            dut_ticks++;
        end
        prev_tick_dut = bus.tick_en;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tick_en"},     {31'd0, bus.tick_en},     32'd0);
        check({tag, "_halted"},      {31'd0, bus.halted},      32'd0);
        check({tag, "_manual_mode"}, {31'd0, bus.manual_mode}, 32'd0);
        check({tag, "_tick_count"},  {16'd0, bus.tick_count},  32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        model_reset();
        prev_tick_dut = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        bit r_sel, r_btn, h, rs;
        int hold, t0;

        bus.manual_btn = 1'b0;
        bus.select     = 1'b0;
        bus.halt       = 1'b0;
        bus.resume     = 1'b0;
        dut_ticks      = 0;

        //           sel btn halt res cyc tick hlt man
        vecs[0]  = '{0, 0, 0, 0, 35, 3, 0, 0};  // auto: ticks at 10,20,30
        vecs[1]  = '{1, 0, 0, 0,  5, 0, 0, 1};  // switch to manual kills the tick due at 40
        vecs[2]  = '{1, 1, 0, 0, 20, 1, 0, 1};  // one press, one tick
        vecs[3]  = '{1, 0, 0, 0, 20, 0, 0, 1};  // release: no tick
        vecs[4]  = '{0, 0, 0, 0, 15, 1, 0, 0};  // back to auto, counter restarted
        vecs[5]  = '{0, 0, 1, 0,  1, 0, 1, 0};  // halt
        vecs[6]  = '{0, 0, 0, 0, 50, 0, 1, 0};  // halted: silent
        vecs[7]  = '{0, 0, 1, 1,  1, 0, 1, 0};  // halt + resume: stays halted
        vecs[8]  = '{0, 0, 0, 1,  1, 0, 0, 0};  // resume
        vecs[9]  = '{0, 0, 0, 0, 10, 1, 0, 0};  // tick 10 cycles after resume
        vecs[10] = '{0, 0, 0, 1,  1, 0, 0, 0};  // resume outside halt: no effect
        vecs[11] = '{0, 0, 0, 0,  9, 1, 0, 0};  // cadence undisturbed

        do_reset();

        for (int i = 0; i < 12; i++) begin
            t0 = dut_ticks;
            repeat (vecs[i].cycles) step(vecs[i].btn, vecs[i].sel, vecs[i].halt, vecs[i].resume);
            check($sformatf("vec%0d_ticks", i),  dut_ticks - t0,               vecs[i].ticks);
            check($sformatf("vec%0d_halted", i), {31'd0, bus.halted},          {31'd0, vecs[i].halted});
            check($sformatf("vec%0d_manual", i), {31'd0, bus.manual_mode},     {31'd0, vecs[i].manual});
        end

        // Exact auto cadence after reset.
        do_reset();
        tick_edges.delete();
        repeat (35) step(0, 0, 0, 0);
        check("auto_tick_num", tick_edges.size(), 3);
        for (int i = 0; i < tick_edges.size() && i < 3; i++)
            check($sformatf("auto_tick%0d_cycle", i), tick_edges[i], 10 * (i + 1));

        // Manual step latency: 7 cycles from the button edge.
        repeat (10) step(0, 1, 0, 0);
        t0 = n;
        tick_edges.delete();
        repeat (20) step(1, 1, 0, 0);
        check("manual_tick_num", tick_edges.size(), 1);
        if (tick_edges.size() > 0) check("manual_latency", tick_edges[0] - t0, 7);
        tick_edges.delete();
        repeat (20) step(0, 1, 0, 0);
        check("release_no_tick", tick_edges.size(), 0);

        // Bouncing button never settles high.
        tick_edges.delete();
        for (int i = 0; i < 4; i++) begin
            repeat (2) step(1, 1, 0, 0);
            repeat (2) step(0, 1, 0, 0);
        end
        repeat (10) step(0, 1, 0, 0);
        check("bounce_no_tick", tick_edges.size(), 0);

        // Counter wrap: preload 0xFFFE, two presses.
        force dut.r_tick_count = 16'hFFFE;
        m_count = 16'hFFFE;
        step(0, 1, 0, 0);
        release dut.r_tick_count;
        for (int i = 0; i < 2; i++) begin
            repeat (10) step(1, 1, 0, 0);
            repeat (10) step(0, 1, 0, 0);
        end
        check("wrap_count", {16'd0, bus.tick_count}, 32'd0);
        repeat (10) step(1, 1, 0, 0);
        repeat (10) step(0, 1, 0, 0);

        // Reset in the middle of a debounce: cleared at once, press lost.
        repeat (3) step(1, 1, 0, 0);
        rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        bus.manual_btn = 1'b0;
        model_reset();
        prev_tick_dut = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick_edges.delete();
        repeat (20) step(0, 1, 0, 0);
        check("reset_press_lost", tick_edges.size(), 0);

        // Randomized traffic against the model.
        r_sel = 1'b0;
        r_btn = 1'b0;
        hold  = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) r_sel = !r_sel;
            if (hold == 0) begin
                r_btn = !r_btn;
                hold  = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : int'($urandom_range(12, 4));
            end
            hold--;
            h  = ($urandom_range(149) == 0);
            rs = ($urandom_range(39) == 0);
            step(r_btn, r_sel, h, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
